// File: rtl/dump_pkg.sv
// Shared types and default constants for the end-of-run register dump unit.
`timescale 1ns/1ps
package dump_pkg;

   // Default build-time constants; instances override them through parameters.
   localparam int unsigned DEF_CYCLE_LIMIT  = 1000;
   localparam int unsigned DEF_DRAIN_CYCLES = 5;
   localparam int unsigned DEF_NUM_REGS     = 32;
   localparam int unsigned DEF_DATA_W       = 32;
   localparam int unsigned DEF_IDX_W        = 5;

   // Dump sequencer states: run, drain the pipeline, then read/send each register.
   typedef enum logic [2:0] {
      RUN   = 3'd0,
      DRAIN = 3'd1,
      READ  = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } dump_state_t;

endpackage

// File: rtl/dump_cycle_counter.sv
// 32-bit run-cycle counter with enable, synchronous clear and terminal compare.
`timescale 1ns/1ps
module dump_cycle_counter #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        enable,
   output logic [31:0] count,
   output logic        terminal
);

   // Count enabled edges; clear has priority over enable.
   always_ff @(posedge clock) begin
      // NOTE: sequential state is always written with non-blocking assignments
      // so every flop samples values from before the edge.
      if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 32'd1;
      end
   end

   // Terminal flags the last run cycle; the edge that sees it still increments.
   assign terminal = (count == 32'(LIMIT - 1));

endmodule

// File: rtl/regfile_dump_unit.sv
// End-of-run register dump: halts the core, drains, then streams every
// architectural register out as one valid/ready beat per register.
`timescale 1ns/1ps
module regfile_dump_unit
   import dump_pkg::*;
#(
   parameter int unsigned CYCLE_LIMIT  = DEF_CYCLE_LIMIT,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned IDX_W        = DEF_IDX_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_dump,
   output logic              halt,
   output logic [IDX_W-1:0]  rf_read_ctrl,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [IDX_W-1:0]  dump_reg,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              done,
   output logic [31:0]       cycle_count
);

   localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REGS - 1);

   dump_state_t       state;
   logic [31:0]       drain_cnt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] data_q;
   logic              at_limit;

   // The cycle counter only advances while the processor is running.
   dump_cycle_counter #(
      .LIMIT (CYCLE_LIMIT)
   ) u_cycle_counter (
      .clock    (clock),
      .clear    (reset),
      .enable   (state == RUN),
      .count    (cycle_count),
      .terminal (at_limit)
   );

   // The index register drives the spare read port and labels each beat, so
   // the read address simply holds the current index outside READ.
   assign rf_read_ctrl = idx;
   assign dump_reg     = idx;
   assign dump_data    = data_q;

   // Dump sequencer with registered halt/valid/last/done outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         drain_cnt  <= '0;
         idx        <= '0;
         // NOTE: the captured-data register is reset as well because it is
         // directly visible on dump_data and must read 0 after reset.
         data_q     <= '0;
         halt       <= 1'b0;
         dump_valid <= 1'b0;
         dump_last  <= 1'b0;
         done       <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (at_limit || start_dump) begin
                  state     <= DRAIN;
                  halt      <= 1'b1;
                  drain_cnt <= '0;
               end
            end

            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= READ;
                  idx   <= '0;
               end else begin
                  drain_cnt <= drain_cnt + 32'd1;
               end
            end

            READ: begin
               data_q     <= rf_read_data;
               dump_valid <= 1'b1;
               dump_last  <= (idx == IDX_LAST);
               state      <= SEND;
            end

            SEND: begin
               // Beat fields stay put until the consumer accepts.
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dump_last  <= 1'b0;
                  if (dump_last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= READ;
                  end
               end
            end

            DONE: begin
               // Sticky until reset; start_dump and dump_ready are ignored.
            end

            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Self-checking bench for regfile_dump_unit: a register-file model feeds the
// spare read port and a scoreboard derives beat order and timing from the
// dump rules (halt edge, drain length, one beat per register).
`timescale 1ns/1ps
module tb_regfile_dump_unit;
   import dump_pkg::*;

   localparam int LIM_A = 10;
   localparam int LIM_B = 1;
   localparam int DRN   = 5;
   localparam int NR    = 32;
   localparam int DW    = 32;
   localparam int IW    = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start_dump = 1'b0;
   logic          dump_ready = 1'b0;
   logic [DW-1:0] regs [NR];

   logic          a_halt, a_valid, a_last, a_done;
   logic [IW-1:0] a_ctrl, a_reg;
   logic [DW-1:0] a_rdata, a_data;
   logic [31:0]   a_cc;
   logic          b_halt, b_valid, b_last, b_done;
   logic [IW-1:0] b_ctrl, b_reg;
   logic [DW-1:0] b_rdata, b_data;
   logic [31:0]   b_cc;

   bit            sel = 1'b0;
   logic          o_halt, o_valid, o_last, o_done;
   logic [IW-1:0] o_ctrl, o_reg;
   logic [DW-1:0] o_data;
   logic [31:0]   o_cc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   assign a_rdata = regs[a_ctrl];
   assign b_rdata = regs[b_ctrl];

   regfile_dump_unit #(
      .CYCLE_LIMIT(LIM_A), .DRAIN_CYCLES(DRN), .NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)
   ) dut (
      .clock(clock), .reset(reset), .start_dump(start_dump), .halt(a_halt),
      .rf_read_ctrl(a_ctrl), .rf_read_data(a_rdata), .dump_valid(a_valid),
      .dump_ready(dump_ready), .dump_reg(a_reg), .dump_data(a_data),
      .dump_last(a_last), .done(a_done), .cycle_count(a_cc)
   );

   regfile_dump_unit #(
      .CYCLE_LIMIT(LIM_B), .DRAIN_CYCLES(DRN), .NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)
   ) dut_min (
      .clock(clock), .reset(reset), .start_dump(start_dump), .halt(b_halt),
      .rf_read_ctrl(b_ctrl), .rf_read_data(b_rdata), .dump_valid(b_valid),
      .dump_ready(dump_ready), .dump_reg(b_reg), .dump_data(b_data),
      .dump_last(b_last), .done(b_done), .cycle_count(b_cc)
   );

   always_comb begin
      if (sel) begin
         o_halt = b_halt; o_valid = b_valid; o_last = b_last; o_done = b_done;
         o_ctrl = b_ctrl; o_reg = b_reg; o_data = b_data; o_cc = b_cc;
      end else begin
         o_halt = a_halt; o_valid = a_valid; o_last = a_last; o_done = a_done;
         o_ctrl = a_ctrl; o_reg = a_reg; o_data = a_data; o_cc = a_cc;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      start_dump = 1'b0;
      dump_ready = 1'b0;
      step();
      reset      = 1'b0;
   endtask

   task automatic fill_linear();
      for (int i = 0; i < NR; i++) regs[i] = DW'(3 * i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
      regs[0] = '0;
   endtask

   // Runs one dump from just after a reset edge (or continues to stop_reg).
   // h: edge after which halt must be high; start_at: edge sampling start_dump
   // (0 = none); mode: 0 ready high, 1 random ready, 2 three-cycle stall on reg 5.
   task automatic run_dump(input string tag, input int h, input int start_at,
                           input int mode, input int stop_reg);
      int            beats = 0;
      int            stalls = 0;
      int            first = h + DRN + 1;
      bit            fin = 1'b0;
      bit            prev_stall = 1'b0;
      bit            rdy;
      logic [IW-1:0] p_reg = '0;
      logic [DW-1:0] p_data = '0;
      logic          p_last = 1'b0;
      for (int n = 0; n < 4000 && !fin; n++) begin
         n_cmp++;
         if (o_halt !== (n >= h)) begin
            n_bad++; $display("FAIL %s halt edge %0d: got %b want %b", tag, n, o_halt, (n >= h));
         end
         n_cmp++;
         if (o_cc !== 32'((n >= h) ? h : n)) begin
            n_bad++; $display("FAIL %s cycle_count edge %0d: got %0d want %0d", tag, n, o_cc, (n >= h) ? h : n);
         end
         n_cmp++;
         if (o_done !== (beats == NR)) begin
            n_bad++; $display("FAIL %s done edge %0d: got %b want %b", tag, n, o_done, (beats == NR));
         end
         if (n < first) begin
            n_cmp++;
            if (o_valid !== 1'b0) begin
               n_bad++; $display("FAIL %s early_valid edge %0d: got %b want 0", tag, n, o_valid);
            end
         end
         if (n == first) begin
            n_cmp++;
            if (o_valid !== 1'b1) begin
               n_bad++; $display("FAIL %s first_valid edge %0d: got %b want 1", tag, n, o_valid);
            end
         end
         if (prev_stall) begin
            n_cmp++;
            if (o_valid !== 1'b1 || o_reg !== p_reg || o_data !== p_data || o_last !== p_last) begin
               n_bad++;
               $display("FAIL %s hold edge %0d: got v=%b r=%0d d=%h l=%b want v=1 r=%0d d=%h l=%b",
                        tag, n, o_valid, o_reg, o_data, o_last, p_reg, p_data, p_last);
            end
         end
         if (beats == NR) begin
            n_cmp++;
            if (o_valid !== 1'b0) begin
               n_bad++; $display("FAIL %s valid_after_done: got %b want 0", tag, o_valid);
            end
            fin = 1'b1;
         end else if (stop_reg >= 0 && o_valid === 1'b1 && o_reg == IW'(stop_reg)) begin
            fin = 1'b1;
         end else begin
            case (mode)
               1:       rdy = ($urandom_range(0, 3) != 0);
               2:       rdy = !(o_valid === 1'b1 && o_reg == IW'(5) && stalls < 3);
               default: rdy = 1'b1;
            endcase
            if (o_valid === 1'b1 && !rdy) stalls++;
            if (o_valid === 1'b1 && rdy) begin
               n_cmp++;
               if (o_reg !== IW'(beats) || o_ctrl !== IW'(beats)) begin
                  n_bad++; $display("FAIL %s beat_reg: got %0d ctrl %0d want %0d", tag, o_reg, o_ctrl, beats);
               end
               n_cmp++;
               if (o_data !== regs[beats]) begin
                  n_bad++; $display("FAIL %s beat_data reg %0d: got %h want %h", tag, beats, o_data, regs[beats]);
               end
               n_cmp++;
               if (o_last !== (beats == NR - 1)) begin
                  n_bad++; $display("FAIL %s beat_last reg %0d: got %b want %b", tag, beats, o_last, (beats == NR - 1));
               end
               beats++;
            end
            prev_stall = (o_valid === 1'b1) && !rdy;
            p_reg  = o_reg;
            p_data = o_data;
            p_last = o_last;
            dump_ready = rdy;
            start_dump = (n + 1 == start_at) || (n + 1 > h && $urandom_range(0, 1) == 1);
            step();
         end
      end
      if (!fin) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: got %0d beats want %0d", tag, beats, NR);
      end
      if (mode == 2) begin
         n_cmp++;
         if (stalls != 3) begin
            n_bad++; $display("FAIL %s stall_count: got %0d want 3", tag, stalls);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_cmp++;
      if ({a_halt, a_valid, a_last, a_done, a_ctrl, a_reg, a_data, a_cc} !== '0) begin
         n_bad++; $display("FAIL reset_a: got h=%b v=%b l=%b d=%b c=%0d r=%0d dat=%h cc=%0d want all 0",
                           a_halt, a_valid, a_last, a_done, a_ctrl, a_reg, a_data, a_cc);
      end
      n_cmp++;
      if ({b_halt, b_valid, b_last, b_done, b_ctrl, b_reg, b_data, b_cc} !== '0) begin
         n_bad++; $display("FAIL reset_b: got h=%b v=%b l=%b d=%b c=%0d r=%0d dat=%h cc=%0d want all 0",
                           b_halt, b_valid, b_last, b_done, b_ctrl, b_reg, b_data, b_cc);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      sel = 1'b0;
      fill_linear();
      apply_reset();
      run_dump("basic", LIM_A, 0, 0, -1);
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      fill_linear();
      apply_reset();
      run_dump("backpressure", LIM_A, 0, 2, -1);
   endtask

   task automatic test_random_stream();
      sel = 1'b0;
      fill_random();
      apply_reset();
      run_dump("random", LIM_A, 0, 1, -1);
   endtask

   task automatic test_early_request();
      sel = 1'b0;
      fill_random();
      apply_reset();
      run_dump("early", 4, 4, 1, -1);
   endtask

   task automatic test_mid_dump_reset();
      sel = 1'b0;
      fill_random();
      apply_reset();
      run_dump("pre_reset", LIM_A, 0, 1, 12);
      n_cmp++;
      if (o_valid !== 1'b1 || o_reg !== IW'(12)) begin
         n_bad++; $display("FAIL mid_reset_reach: got v=%b r=%0d want v=1 r=12", o_valid, o_reg);
      end
      reset = 1'b1;
      dump_ready = 1'b0;
      step();
      n_cmp++;
      if (o_valid !== 1'b0 || o_halt !== 1'b0 || o_cc !== 32'd0 || o_done !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_outputs: got v=%b h=%b cc=%0d d=%b want 0 0 0 0",
                           o_valid, o_halt, o_cc, o_done);
      end
      reset = 1'b0;
      run_dump("post_reset", LIM_A, 0, 0, -1);
   endtask

   task automatic test_min_limit();
      sel = 1'b1;
      fill_random();
      apply_reset();
      run_dump("min_limit", LIM_B, 0, 0, -1);
      sel = 1'b0;
   endtask

   task automatic test_post_done();
      sel = 1'b0;
      fill_random();
      apply_reset();
      run_dump("pre_done", LIM_A, 0, 1, -1);
      for (int i = 0; i < 20; i++) begin
         start_dump = 1'($urandom_range(0, 1));
         dump_ready = 1'($urandom_range(0, 1));
         step();
         n_cmp++;
         if (o_done !== 1'b1 || o_halt !== 1'b1 || o_valid !== 1'b0) begin
            n_bad++; $display("FAIL post_done cycle %0d: got d=%b h=%b v=%b want 1 1 0",
                              i, o_done, o_halt, o_valid);
         end
      end
      start_dump = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_random_stream();
      test_early_request();
      test_mid_dump_reset();
      test_min_limit();
      test_post_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/regfile_dump_unit.md
# regfile_dump_unit

Synthesizable end-of-run register dump transmitter. It counts processor cycles after reset, halts the processor at a cycle limit or on request, waits for the pipeline to drain, then reads all architectural registers through a spare register-file read port. Each register goes out as one beat on a valid/ready stream, so a bench or host checker can compare results without hierarchical probes into the register file. It sits in `skeleton` beside `my_processor` and `my_regfile`.

## Interface
Parameters:
- `CYCLE_LIMIT`, 1000: run cycles before an automatic dump; must be ≥1.
- `DRAIN_CYCLES`, 5: idle cycles after halt before the first register read; must be ≥1.
- `NUM_REGS`, 32: registers dumped, indices 0..NUM_REGS-1.
- `DATA_W`, 32: register width.
- `IDX_W`, 5: register index width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start_dump` in 1: early dump request; sampled only in RUN.
- `halt` out 1: stall/freeze request to the processor.
- `rf_read_ctrl` out IDX_W: register-file read address.
- `rf_read_data` in DATA_W: combinational register-file read data.
- `dump_valid` out 1: beat valid.
- `dump_ready` in 1: consumer accepts the beat.
- `dump_reg` out IDX_W: register index of the beat.
- `dump_data` out DATA_W: register value.
- `dump_last` out 1: high on the final beat (index NUM_REGS-1).
- `done` out 1: dump complete; sticky until reset.
- `cycle_count` out 32: run cycles elapsed.

## Operation
States: RUN, DRAIN, READ, SEND, DONE.

- **RUN**
  - `cycle_count` increments every edge.
  - When `cycle_count == CYCLE_LIMIT-1`, or `start_dump`=1, the next state is DRAIN. `cycle_count` still takes its incremented value on that edge.
- **DRAIN**
  - `halt`=1.
  - Drain counter runs 0..DRAIN_CYCLES-1, then the next state is READ with index=0.
  - `cycle_count` frozen.
- **READ**
  - `rf_read_ctrl`=index.
  - On the edge, `rf_read_data` is captured into the data register and the next state is SEND.
- **SEND**
  - `dump_valid`=1, `dump_reg`=index, `dump_data`=captured value.
  - `dump_last`=(index==NUM_REGS-1).
  - On `dump_valid && dump_ready`: if last, go to DONE; otherwise index+1 and go to READ.
- **DONE**
  - `done`=1, `halt`=1, `dump_valid`=0. Held until reset.

Rules:
- `halt` is high in every state except RUN.
- `dump_reg`, `dump_data` and `dump_last` are stable while `dump_valid && !dump_ready`.
- `dump_ready` is ignored when `dump_valid`=0.
- `start_dump` is ignored outside RUN.
- Register 0 is dumped like any other register (expected value 0).
- `rf_read_ctrl` holds the current index outside READ.
- The index never wraps; its last value is NUM_REGS-1.

## Timing
- Reset values: state RUN, `cycle_count`=0, `halt`=0, `rf_read_ctrl`=0, `dump_valid`=0, `dump_reg`=0, `dump_data`=0, `dump_last`=0, `done`=0.
- `reset` mid-dump (any state) returns to RUN with all outputs at reset values on the next edge, and counting restarts from 0.
- Auto trigger: `halt` rises after edge CYCLE_LIMIT (counting the first post-reset edge as 1), and `cycle_count` freezes at CYCLE_LIMIT.
- Trigger by `start_dump` sampled at edge k: `halt` rises after edge k and `cycle_count` freezes at k.
- First `dump_valid` is DRAIN_CYCLES+1 edges after `halt` rises.
- Per register: 1 READ cycle plus ≥1 SEND cycle. With `dump_ready` tied high, one beat every 2 cycles and the whole dump takes 2·NUM_REGS cycles.
- `done` rises on the edge that accepts the last beat, and `dump_valid` falls on that same edge.

## Structure
- Shared package `dump_pkg`:
  - state enum {RUN, DRAIN, READ, SEND, DONE}
  - default constants: `CYCLE_LIMIT`, `DRAIN_CYCLES`, `NUM_REGS`, `DATA_W`, `IDX_W`
- One natural sub-module: `dump_cycle_counter`, a 32-bit counter with enable, synchronous clear and a terminal-compare output. The FSM, index register and data register stay in `regfile_dump_unit`.
- The register-file read uses a dedicated extra read port; the processor's ports are not muxed.

## Test plan
- **Basic dump:** CYCLE_LIMIT=10, DRAIN_CYCLES=5, `dump_ready`=1, rN preloaded to 3·N (r0=0) -> `halt` after edge 10; first beat after edge 16 (reg 0, data 0); 32 beats every 2 cycles; last beat reg 31, data 0x5D with `dump_last`=1; then `done`=1.
- **Backpressure:** as above, `dump_ready`=0 for 3 cycles while reg 5 is valid -> `dump_reg`=5 and `dump_data`=0xF held stable; next beat is reg 6; no beat skipped or duplicated.
- **Early request:** CYCLE_LIMIT=1000, `start_dump` pulsed at edge 4 -> `halt` after edge 4; `cycle_count` frozen at 4; full 32-beat dump follows.
- **Mid-dump reset:** `reset` asserted while reg 12 is valid -> next edge: `dump_valid`=0, `halt`=0, `cycle_count`=0, `done`=0; after release, a full dump repeats at cycle CYCLE_LIMIT.
- **Minimum limit and stray ready:** CYCLE_LIMIT=1 -> `halt` after the first edge. `dump_ready` held high through DRAIN/READ -> no index advance until `dump_valid`.
- **Post-done stability:** after `done`, toggle `start_dump` and `dump_ready` for 20 cycles -> `done`=1, `halt`=1 and `dump_valid`=0 unchanged.
